// File: rtl/apb_gpio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : apb_gpio_pkg                                                  |
// | Description: Shared constants and types for the APB GPIO controller:       |
// |              register indices, lock FSM states, interrupt types, default   |
// |              lock keys and bank-count helpers.                             |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package apb_gpio_pkg;

    // Register index, taken from PADDR[11:8]
    localparam logic [3:0] REG_DIR      = 4'd0;
    localparam logic [3:0] REG_IN       = 4'd1;
    localparam logic [3:0] REG_OUT      = 4'd2;
    localparam logic [3:0] REG_INTEN    = 4'd3;
    localparam logic [3:0] REG_INTTYPE0 = 4'd4;
    localparam logic [3:0] REG_INTTYPE1 = 4'd5;
    localparam logic [3:0] REG_STATUS   = 4'd6;
    localparam logic [3:0] REG_LOCK     = 4'd7;
    localparam logic [3:0] REG_PADCFG   = 4'd8;

    typedef enum logic [1:0] {
        LOCK_UNLOCKED = 2'd0,
        LOCK_LOCKED   = 2'd1,
        LOCK_ARMED    = 2'd2
    } lock_state_e;

    // Encoding is {INTTYPE1[k], INTTYPE0[k]}
    typedef enum logic [1:0] {
        INT_LEVEL_HI = 2'd0,
        INT_LEVEL_LO = 2'd1,
        INT_RISE     = 2'd2,
        INT_FALL     = 2'd3
    } int_type_e;

    localparam logic [31:0] DEF_LOCK_KEY    = 32'hC0DE_0001;
    localparam logic [31:0] DEF_UNLOCK_KEY1 = 32'hA5A5_0F0F;
    localparam logic [31:0] DEF_UNLOCK_KEY2 = 32'h5A5A_F0F0;

    // Number of 32-pin banks needed for n pins
    function automatic int num_banks(input int n);
        return (n + 31) / 32;
    endfunction

    // Number of PADCFG words (four pins per word) needed for n pins
    function automatic int num_pad_words(input int n);
        return (n + 3) / 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_gpio_param_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : gpio_in_sync_edge                                             |
// | Description: Multi-flop synchroniser for raw pad inputs plus a one-cycle   |
// |              delayed copy used for level and edge detection.               |
// |   clk_i    in   clock                                                      |
// |   rst_ni   in   synchronous active-low reset                               |
// |   async_i  in   raw asynchronous pad inputs                                |
// |   sync_o   out  synchronised inputs (STAGES cycles latency)                |
// |   level_o  out  sync_o delayed one cycle (level event source)              |
// |   rise_o   out  registered rising-edge event, aligned with level_o         |
// |   fall_o   out  registered falling-edge event, aligned with level_o        |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module gpio_in_sync_edge #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    logic [WIDTH-1:0]             prev_q;
    logic [WIDTH-1:0]             rise_q;
    logic [WIDTH-1:0]             fall_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            chain_q <= '0;
            prev_q  <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            chain_q[0] <= async_i;
            for (int s = 1; s < STAGES; s++) begin
                chain_q[s] <= chain_q[s-1];
            end
            // All event sources are registered so level and edge types share
            // the same latency from sync_o.
            prev_q <= chain_q[STAGES-1];
            rise_q <= chain_q[STAGES-1] & ~prev_q;
            fall_q <= ~chain_q[STAGES-1] & prev_q;
        end
    end

    assign sync_o  = chain_q[STAGES-1];
    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/apb_gpio_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : apb_gpio_param                                                |
// | Description: APB GPIO controller with banked direction/output/interrupt    |
// |              registers, per-pin pad configuration, W1C interrupt status    |
// |              and a key-sequenced configuration lock.                       |
// |   HCLK/HRESETn        clock, synchronous active-low reset                  |
// |   PADDR..PSLVERR      zero-wait-state APB slave                            |
// |   gpio_in             raw pad inputs          gpio_in_sync  synchronised   |
// |   gpio_out/gpio_dir   output value/enable     gpio_padcfg   pad config     |
// |   interrupt           registered OR of STATUS                              |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module apb_gpio_param
    import apb_gpio_pkg::*;
#(
    parameter int          NUM_GPIO    = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int          PAD_W       = 6,
    parameter logic [31:0] LOCK_KEY    = DEF_LOCK_KEY,
    parameter logic [31:0] UNLOCK_KEY1 = DEF_UNLOCK_KEY1,
    parameter logic [31:0] UNLOCK_KEY2 = DEF_UNLOCK_KEY2
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,
    input  logic [11:0]                    PADDR,
    input  logic [31:0]                    PWDATA,
    input  logic                           PWRITE,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    output logic [31:0]                    PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    input  logic [NUM_GPIO-1:0]            gpio_in,
    output logic [NUM_GPIO-1:0]            gpio_in_sync,
    output logic [NUM_GPIO-1:0]            gpio_out,
    output logic [NUM_GPIO-1:0]            gpio_dir,
    output logic [NUM_GPIO-1:0][PAD_W-1:0] gpio_padcfg,
    output logic                           interrupt
);

    localparam int NB  = num_banks(NUM_GPIO);
    localparam int NPW = num_pad_words(NUM_GPIO);
    localparam int BW  = NB * 32;

    logic [NUM_GPIO-1:0]            dir_q, dir_d, out_q, out_d, inten_q, inten_d;
    logic [NUM_GPIO-1:0]            type0_q, type0_d, type1_q, type1_d, status_q, status_d;
    logic [NUM_GPIO-1:0][PAD_W-1:0] padcfg_q, padcfg_d;
    logic                           irq_q;
    lock_state_e                    lock_q;

    logic [NUM_GPIO-1:0] lvl_w, rise_w, fall_w, ev_w, hit_w, wbit_w, w1c_w;
    logic [3:0]          reg_w;
    logic [5:0]          idx_w;
    logic                access_w, wr_w, mapped_w, prot_w, err_w, we_w, lock_wr_w;
    logic [BW-1:0]       src_w;
    logic [31:0]         bank_w, pad_w, rdata_w;

    gpio_in_sync_edge #(
        .WIDTH  (NUM_GPIO),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .async_i (gpio_in),
        .sync_o  (gpio_in_sync),
        .level_o (lvl_w),
        .rise_o  (rise_w),
        .fall_o  (fall_w)
    );

    // Address decode and error response
    assign reg_w     = PADDR[11:8];
    assign idx_w     = PADDR[7:2];
    assign access_w  = PSEL & PENABLE;
    assign wr_w      = access_w & PWRITE;
    assign lock_wr_w = (reg_w == REG_LOCK) && (idx_w == 6'd0);
    assign prot_w    = (reg_w == REG_DIR) || (reg_w == REG_OUT) || (reg_w == REG_PADCFG) ||
                       (reg_w == REG_INTTYPE0) || (reg_w == REG_INTTYPE1);

    always_comb begin
        mapped_w = 1'b0;
        if (reg_w <= REG_STATUS) begin
            mapped_w = (int'(idx_w) < NB);
        end else if (reg_w == REG_LOCK) begin
            mapped_w = (idx_w == 6'd0);
        end else if (reg_w == REG_PADCFG) begin
            mapped_w = (int'(idx_w) < NPW);
        end
    end

    // ARMED counts as locked: a non-key write in ARMED is still checked.
    assign err_w   = access_w & (~mapped_w | (PWRITE & ((reg_w == REG_IN) |
                     ((lock_q != LOCK_UNLOCKED) & prot_w))));
    assign we_w    = wr_w & ~err_w;
    assign PSLVERR = err_w & HRESETn;
    assign PREADY  = 1'b1;

    // Read path: registers are zero-padded to whole banks so missing pins read 0
    always_comb begin
        src_w = '0;
        case (reg_w)
            REG_DIR:      src_w = BW'(dir_q);
            REG_IN:       src_w = BW'(gpio_in_sync);
            REG_OUT:      src_w = BW'(out_q);
            REG_INTEN:    src_w = BW'(inten_q);
            REG_INTTYPE0: src_w = BW'(type0_q);
            REG_INTTYPE1: src_w = BW'(type1_q);
            REG_STATUS:   src_w = BW'(status_q);
            default:      src_w = '0;
        endcase
        bank_w = '0;
        for (int b = 0; b < NB; b++) begin
            if (int'(idx_w) == b) bank_w = src_w[b*32 +: 32];
        end
        pad_w = '0;
        for (int k = 0; k < NUM_GPIO; k++) begin
            if (int'(idx_w) == k / 4) pad_w[8*(k%4) +: PAD_W] = padcfg_q[k];
        end
        rdata_w = '0;
        if (mapped_w) begin
            if (reg_w <= REG_STATUS)     rdata_w = bank_w;
            else if (reg_w == REG_LOCK)  rdata_w = {30'b0, lock_q};
            else                         rdata_w = pad_w;
        end
    end

    assign PRDATA = (PSEL & ~PWRITE) ? rdata_w : 32'h0;

    // Interrupt event per pin
    always_comb begin
        ev_w = '0;
        for (int k = 0; k < NUM_GPIO; k++) begin
            case (int_type_e'({type1_q[k], type0_q[k]}))
                INT_LEVEL_HI: ev_w[k] = lvl_w[k];
                INT_LEVEL_LO: ev_w[k] = ~lvl_w[k];
                INT_RISE:     ev_w[k] = rise_w[k];
                default:      ev_w[k] = fall_w[k];
            endcase
        end
    end

    // Write path: hit_w marks the pins of the addressed bank
    always_comb begin
        hit_w  = '0;
        wbit_w = '0;
        for (int k = 0; k < NUM_GPIO; k++) begin
            if (int'(idx_w) == k / 32) begin
                hit_w[k]  = 1'b1;
                wbit_w[k] = PWDATA[k%32];
            end
        end
        dir_d    = dir_q;
        out_d    = out_q;
        inten_d  = inten_q;
        type0_d  = type0_q;
        type1_d  = type1_q;
        padcfg_d = padcfg_q;
        w1c_w    = '0;
        if (we_w) begin
            case (reg_w)
                REG_DIR:      dir_d   = (dir_q   & ~hit_w) | wbit_w;
                REG_OUT:      out_d   = (out_q   & ~hit_w) | wbit_w;
                REG_INTEN:    inten_d = (inten_q & ~hit_w) | wbit_w;
                REG_INTTYPE0: type0_d = (type0_q & ~hit_w) | wbit_w;
                REG_INTTYPE1: type1_d = (type1_q & ~hit_w) | wbit_w;
                REG_STATUS:   w1c_w   = wbit_w;
                REG_PADCFG: begin
                    for (int k = 0; k < NUM_GPIO; k++) begin
                        if (int'(idx_w) == k / 4) padcfg_d[k] = PWDATA[8*(k%4) +: PAD_W];
                    end
                end
                default: ;
            endcase
        end
        // A new event overrides a simultaneous W1C clear
        status_d = (status_q & ~w1c_w) | (inten_q & ev_w);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dir_q    <= '0;
            out_q    <= '0;
            inten_q  <= '0;
            type0_q  <= '0;
            type1_q  <= '0;
            status_q <= '0;
            padcfg_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            dir_q    <= dir_d;
            out_q    <= out_d;
            inten_q  <= inten_d;
            type0_q  <= type0_d;
            type1_q  <= type1_d;
            status_q <= status_d;
            padcfg_q <= padcfg_d;
            irq_q    <= |status_q;
        end
    end

    // Lock FSM: any APB write while ARMED either completes the unlock or re-locks
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            lock_q <= LOCK_UNLOCKED;
        end else if (wr_w) begin
            case (lock_q)
                LOCK_UNLOCKED: if (lock_wr_w && PWDATA == LOCK_KEY)    lock_q <= LOCK_LOCKED;
                LOCK_LOCKED:   if (lock_wr_w && PWDATA == UNLOCK_KEY1) lock_q <= LOCK_ARMED;
                LOCK_ARMED:    lock_q <= (lock_wr_w && PWDATA == UNLOCK_KEY2) ?
                                         LOCK_UNLOCKED : LOCK_LOCKED;
                default:       lock_q <= LOCK_LOCKED;
            endcase
        end
    end

    assign gpio_out    = out_q;
    assign gpio_dir    = dir_q;
    assign gpio_padcfg = padcfg_q;
    assign interrupt   = irq_q;

    // Byte-lane bits of PADDR and PAD_W-unused PWDATA bits are intentionally ignored
    logic unused_ok;
    assign unused_ok = &{1'b0, PADDR[1:0], PWDATA};

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_apb_gpio_param                                             |
// | Description: Self-checking bench for apb_gpio_param (40 pins). APB         |
// |              responses go through an expected-response queue checked by a  |
// |              monitor; a per-pin register model supplies expected values.   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_apb_gpio_param;

    localparam int          NG    = 40;
    localparam int          NB    = 2;
    localparam int          NPW   = 10;
    localparam int          SS    = 2;
    localparam logic [31:0] LKEY  = 32'hC0DE_0001;
    localparam logic [31:0] UKEY1 = 32'hA5A5_0F0F;
    localparam logic [31:0] UKEY2 = 32'h5A5A_F0F0;

    logic               HCLK = 1'b0;
    logic               HRESETn = 1'b0;
    logic [11:0]        PADDR = '0;
    logic [31:0]        PWDATA = '0;
    logic               PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
    logic [31:0]        PRDATA;
    logic               PREADY, PSLVERR;
    logic [NG-1:0]      gpio_in = '0;
    logic [NG-1:0]      gpio_in_sync, gpio_out, gpio_dir;
    logic [NG-1:0][5:0] gpio_padcfg;
    logic               interrupt;

    apb_gpio_param #(.NUM_GPIO(NG), .SYNC_STAGES(SS), .PAD_W(6)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .gpio_in(gpio_in),
        .gpio_in_sync(gpio_in_sync), .gpio_out(gpio_out), .gpio_dir(gpio_dir),
        .gpio_padcfg(gpio_padcfg), .interrupt(interrupt)
    );

    always #5 HCLK = ~HCLK;

    int n_chk = 0;
    int n_fail = 0;
    int txn = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          id;
        int          rg;
        bit          chk_rd;
        logic [31:0] rd;
        bit          err;
        bit          chk_irq;
        bit          irq;
    } exp_t;
    exp_t sb_q[$];

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (PSEL && PENABLE) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_access", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("pslverr txn=%0d reg=%0d", e.id, e.rg), 64'(PSLVERR), 64'(e.err));
                    chk($sformatf("pready txn=%0d", e.id), 64'(PREADY), 64'd1);
                    if (e.chk_rd)
                        chk($sformatf("prdata txn=%0d reg=%0d", e.id, e.rg), 64'(PRDATA), 64'(e.rd));
                    if (e.chk_irq)
                        chk($sformatf("interrupt txn=%0d", e.id), 64'(interrupt), 64'(e.irq));
                end
            end
        end
    end

    task automatic apb(input bit wr, input int rg, input int idx, input logic [31:0] d,
                       input bit chk_rd, input logic [31:0] exp_rd, input bit exp_err,
                       input bit chk_irq, input bit exp_irq, input bit rst_mid);
        exp_t e;
        @(posedge HCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = {rg[3:0], idx[5:0], 2'b00};
        PWDATA = wr ? d : 32'h0;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        e.id = txn; e.rg = rg; e.chk_rd = chk_rd; e.rd = exp_rd; e.err = exp_err;
        e.chk_irq = chk_irq; e.irq = exp_irq;
        sb_q.push_back(e);
        txn++;
        if (rst_mid) HRESETn = 1'b0;
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        HRESETn = 1'b1;
    endtask

    task automatic wr_reg(input int rg, input int idx, input logic [31:0] d, input bit exp_err);
        apb(1'b1, rg, idx, d, 1'b0, 32'h0, exp_err, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd_reg(input int rg, input int idx, input logic [31:0] exp_rd, input bit exp_err);
        apb(1'b0, rg, idx, 32'h0, 1'b1, exp_rd, exp_err, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge HCLK); #1;
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
    endtask

    // ---------------- reference model ----------------
    bit          m_dir[NG], m_out[NG], m_inten[NG], m_t0[NG], m_t1[NG], m_st[NG];
    logic [7:0]  m_pad[NG];
    int          m_lock;

    function automatic void m_reset();
        for (int k = 0; k < NG; k++) begin
            m_dir[k] = 0; m_out[k] = 0; m_inten[k] = 0; m_t0[k] = 0; m_t1[k] = 0;
            m_st[k] = 0; m_pad[k] = 8'h0;
        end
        m_lock = 0;
    endfunction

    function automatic bit m_mapped(input int rg, input int idx);
        if (rg <= 6) return idx < NB;
        if (rg == 7) return idx == 0;
        if (rg == 8) return idx < NPW;
        return 1'b0;
    endfunction

    function automatic bit m_err(input bit wr, input int rg, input int idx);
        if (!m_mapped(rg, idx)) return 1'b1;
        if (!wr) return 1'b0;
        if (rg == 1) return 1'b1;
        return (m_lock != 0) && (rg == 0 || rg == 2 || rg == 4 || rg == 5 || rg == 8);
    endfunction

    // With static inputs only the level types ever fire
    function automatic bit m_ev(input int k);
        if (m_t1[k]) return 1'b0;
        return m_t0[k] ? !gpio_in[k] : gpio_in[k];
    endfunction

    function automatic bit m_irq();
        bit r = 0;
        for (int k = 0; k < NG; k++) r |= m_st[k];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int rg, input int idx);
        logic [31:0] r = '0;
        int p;
        if (!m_mapped(rg, idx)) return 32'h0;
        if (rg == 7) return 32'(m_lock);
        if (rg == 8) begin
            for (int j = 0; j < 4; j++) begin
                p = 4 * idx + j;
                if (p < NG) r[8*j +: 8] = m_pad[p] & 8'h3F;
            end
            return r;
        end
        for (int j = 0; j < 32; j++) begin
            p = 32 * idx + j;
            if (p < NG) begin
                case (rg)
                    0: r[j] = m_dir[p];
                    1: r[j] = gpio_in[p];
                    2: r[j] = m_out[p];
                    3: r[j] = m_inten[p];
                    4: r[j] = m_t0[p];
                    5: r[j] = m_t1[p];
                    default: r[j] = m_st[p];
                endcase
            end
        end
        return r;
    endfunction

    function automatic void m_write(input int rg, input int idx, input logic [31:0] d);
        bit so[NG];
        bit lw;
        int p;
        lw = (rg == 7) && (idx == 0);
        for (int k = 0; k < NG; k++) so[k] = m_inten[k] & m_ev(k);
        if (!m_err(1'b1, rg, idx)) begin
            if (rg == 8) begin
                for (int j = 0; j < 4; j++) begin
                    p = 4 * idx + j;
                    if (p < NG) m_pad[p] = d[8*j +: 8] & 8'h3F;
                end
            end else if (rg <= 6) begin
                for (int j = 0; j < 32; j++) begin
                    p = 32 * idx + j;
                    if (p < NG) begin
                        case (rg)
                            0: m_dir[p] = d[j];
                            2: m_out[p] = d[j];
                            3: m_inten[p] = d[j];
                            4: m_t0[p] = d[j];
                            5: m_t1[p] = d[j];
                            6: if (d[j]) m_st[p] = 0;
                            default: ;
                        endcase
                    end
                end
            end
        end
        // Events seen under the old and the new settings both land in STATUS
        for (int k = 0; k < NG; k++) m_st[k] = m_st[k] | so[k] | (m_inten[k] & m_ev(k));
        case (m_lock)
            0: if (lw && d == LKEY) m_lock = 1;
            1: if (lw && d == UKEY1) m_lock = 2;
            default: m_lock = (lw && d == UKEY2) ? 0 : 1;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin : timeout
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        bit wr;
        int rg, idx;
        logic [31:0] d;
        logic [NG-1:0] vdir, vout;

        do_reset();
        // Reset state
        chk("reset_interrupt", 64'(interrupt), 64'd0);
        chk("reset_pslverr", 64'(PSLVERR), 64'd0);
        chk("reset_gpio_dir", 64'(gpio_dir), 64'd0);
        rd_reg(0, 0, 32'h0, 1'b0);
        rd_reg(2, 0, 32'h0, 1'b0);
        rd_reg(6, 0, 32'h0, 1'b0);
        rd_reg(7, 0, 32'h0, 1'b0);

        // Partial upper bank
        wr_reg(2, 1, 32'hFFFF_FFFF, 1'b0);
        chk("out_upper_pins", 64'(gpio_out[39:32]), 64'hFF);
        chk("out_lower_pins", 64'(gpio_out[31:0]), 64'h0);
        rd_reg(2, 1, 32'h0000_00FF, 1'b0);
        wr_reg(2, 2, 32'h1, 1'b1);
        rd_reg(2, 2, 32'h0, 1'b1);
        rd_reg(9, 0, 32'h0, 1'b1);

        // Rising-edge interrupt latency on pin 3
        wr_reg(5, 0, 32'h8, 1'b0);
        wr_reg(3, 0, 32'h8, 1'b0);
        @(posedge HCLK); #1;
        gpio_in[3] = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge HCLK); #1;
            n++;
            if (interrupt) break;
        end
        chk("rise_irq_latency", 64'(n), 64'(SS + 3));
        rd_reg(6, 0, 32'h8, 1'b0);
        wr_reg(6, 0, 32'h8, 1'b0);
        rd_reg(6, 0, 32'h0, 1'b0);
        chk("irq_after_w1c", 64'(interrupt), 64'd0);
        wr_reg(3, 0, 32'h0, 1'b0);
        gpio_in[3] = 1'b0;

        // Lock engaged
        wr_reg(7, 0, LKEY, 1'b0);
        rd_reg(7, 0, 32'h1, 1'b0);
        wr_reg(0, 0, 32'h1, 1'b1);
        chk("dir_locked", 64'(gpio_dir), 64'h0);
        wr_reg(3, 0, 32'h1, 1'b0);
        rd_reg(3, 0, 32'h1, 1'b0);
        wr_reg(3, 0, 32'h0, 1'b0);
        // KEY1, interrupting write, KEY2 -> stays locked
        wr_reg(7, 0, UKEY1, 1'b0);
        rd_reg(7, 0, 32'h2, 1'b0);
        rd_reg(7, 0, 32'h2, 1'b0);
        wr_reg(2, 0, 32'h5, 1'b1);
        wr_reg(7, 0, UKEY2, 1'b0);
        rd_reg(7, 0, 32'h1, 1'b0);
        // KEY1 then KEY2 back to back -> unlocked
        wr_reg(7, 0, UKEY1, 1'b0);
        wr_reg(7, 0, UKEY2, 1'b0);
        rd_reg(7, 0, 32'h0, 1'b0);
        wr_reg(0, 0, 32'h1, 1'b0);
        chk("dir_unlocked", 64'(gpio_dir), 64'h1);

        // Level-high with W1C in the same cycle as a re-set
        wr_reg(5, 0, 32'h0, 1'b0);
        wr_reg(3, 0, 32'h20, 1'b0);
        gpio_in[5] = 1'b1;
        repeat (8) @(posedge HCLK);
        wr_reg(6, 0, 32'h20, 1'b0);
        apb(1'b0, 6, 0, 32'h0, 1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0);
        wr_reg(3, 0, 32'h0, 1'b0);
        wr_reg(6, 0, 32'h20, 1'b0);
        rd_reg(6, 0, 32'h0, 1'b0);
        gpio_in[5] = 1'b0;

        // Reset during the access phase of a write
        apb(1'b1, 0, 1, 32'hFF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_dir", 64'(gpio_dir), 64'h0);
        rd_reg(0, 1, 32'h0, 1'b0);

        // Randomised register traffic against the model
        do_reset();
        m_reset();
        gpio_in = NG'({$urandom, $urandom});
        repeat (6) @(posedge HCLK);
        for (int t = 0; t < 300; t++) begin
            wr  = ($urandom_range(0, 9) < 6);
            rg  = int'($urandom_range(0, 9));
            if (rg == 8)      idx = int'($urandom_range(0, 10));
            else if (rg == 7) idx = ($urandom_range(0, 7) == 0) ? 1 : 0;
            else              idx = int'($urandom_range(0, 2));
            d = $urandom;
            if (rg == 7) begin
                case ($urandom_range(0, 3))
                    0: d = LKEY;
                    1: d = UKEY1;
                    2: d = UKEY2;
                    default: ;
                endcase
            end
            if (m_lock == 2 && $urandom_range(0, 1) == 1) begin
                wr = 1'b1; rg = 7; idx = 0; d = UKEY2;
            end
            apb_rand(wr, rg, idx, d);
        end
        for (int k = 0; k < NG; k++) begin
            vdir[k] = m_dir[k];
            vout[k] = m_out[k];
        end
        chk("final_gpio_dir", 64'(gpio_dir), 64'(vdir));
        chk("final_gpio_out", 64'(gpio_out), 64'(vout));
        for (int k = 0; k < NG; k++)
            chk($sformatf("final_padcfg pin=%0d", k), 64'(gpio_padcfg[k]), 64'(m_pad[k][5:0]));
        chk("final_in_sync", 64'(gpio_in_sync), 64'(gpio_in));

        repeat (2) @(posedge HCLK);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    task automatic apb_rand(input bit wr, input int rg, input int idx, input logic [31:0] d);
        bit          e_err;
        bit          e_irq;
        logic [31:0] e_rd;
        e_err = m_err(wr, rg, idx);
        e_irq = m_irq();
        e_rd  = wr ? 32'h0 : m_read(rg, idx);
        if (wr) m_write(rg, idx, d);
        apb(wr, rg, idx, d, !wr, e_rd, e_err, 1'b1, e_irq, 1'b0);
    endtask

endmodule
`default_nettype wire
